// File: rtl/sdram_arbiter_if.sv
// Avalon-MM command/response bundle shared by the requester ports and the SDRAM-facing port.
interface sdram_arbiter_if;
    logic        waitrequest;
    logic [31:0] address;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        write;
    logic [31:0] writedata;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, read, write, writedata
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  address, read, write, writedata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-requester round-robin Avalon-MM arbiter with grant lock on stall and an
// in-order owner FIFO that steers pipelined read responses back to their issuer.
module sdram_arbiter #(
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned PW          = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_arbiter_if.slave        r0,
    sdram_arbiter_if.slave        r1,
    sdram_arbiter_if.master       master,
    output logic [PW-1:0]         pending_count,
    output logic                  err_unexpected
);

    localparam int unsigned AW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

    typedef enum logic {
        S_OPEN   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_lock_owner;
    logic            w_lock_owner_nxt;
    logic            r_ptr;
    logic            w_ptr_nxt;

    logic            r_fifo [MAX_PENDING];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_count;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic            w_elig0;
    logic            w_elig1;
    logic            w_gnt;
    logic            w_owner;
    logic            w_sel_rd;
    logic            w_sel_wr;
    logic            w_cmd;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_head;

    assign w_full  = (r_count == PW'(MAX_PENDING));
    assign w_empty = (r_count == '0);

    // Read wins over write when both strobes are up; reads need a free FIFO slot.
    assign w_elig0 = r0.read ? ~w_full : r0.write;
    assign w_elig1 = r1.read ? ~w_full : r1.write;

    // Grant selection, lock tracking and round-robin pointer update.
    always_comb begin
        w_gnt            = 1'b0;
        w_owner          = r_ptr;
        w_state_nxt      = S_OPEN;
        w_lock_owner_nxt = r_lock_owner;
        w_ptr_nxt        = r_ptr;

        case (r_state)
            S_LOCKED: begin
                w_gnt   = 1'b1;
                w_owner = r_lock_owner;
            end
            default: begin
                if (w_elig0 && w_elig1) begin
                    w_gnt   = 1'b1;
                    w_owner = r_ptr;
                end else if (w_elig0) begin
                    w_gnt   = 1'b1;
                    w_owner = 1'b0;
                end else if (w_elig1) begin
                    w_gnt   = 1'b1;
                    w_owner = 1'b1;
                end
            end
        endcase

        w_sel_rd = w_owner ? r1.read  : r0.read;
        w_sel_wr = w_owner ? r1.write : r0.write;
        w_cmd    = w_gnt & (w_sel_rd | w_sel_wr);
        w_accept = w_cmd & ~master.waitrequest;

        // A stalled command pins the grant; a dropped command releases it.
        if (w_cmd && master.waitrequest) begin
            w_state_nxt      = S_LOCKED;
            w_lock_owner_nxt = w_owner;
        end

        if (w_accept) begin
            w_ptr_nxt = ~w_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_OPEN;
            r_lock_owner <= 1'b0;
            r_ptr        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_ptr        <= w_ptr_nxt;
        end
    end

    // Command path forwarding; everything is forced idle while reset is held.
    assign master.address   = w_owner ? r1.address   : r0.address;
    assign master.writedata = w_owner ? r1.writedata : r0.writedata;
    assign master.read      = rst_n & w_gnt & w_sel_rd;
    assign master.write     = rst_n & w_gnt & w_sel_wr & ~w_sel_rd;

    assign r0.waitrequest   = ~(rst_n & w_gnt & ~w_owner) | master.waitrequest;
    assign r1.waitrequest   = ~(rst_n & w_gnt &  w_owner) | master.waitrequest;

    // Response routing from the FIFO head.
    assign w_push = w_accept & w_sel_rd;
    assign w_pop  = master.readdatavalid & ~w_empty;
    assign w_head = r_fifo[r_rd_ptr];

    assign r0.readdatavalid = rst_n & w_pop & ~w_head;
    assign r1.readdatavalid = rst_n & w_pop &  w_head;
    assign r0.readdata      = master.readdata;
    assign r1.readdata      = master.readdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_PENDING; i++) begin
                r_fifo[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_owner;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
            if (master.readdatavalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pending_count  = r_count;
    assign err_unexpected = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scenario bench for sdram_arbiter: requesters and SDRAM are driven from tasks,
// read responses are checked against a queue of expected owner/data pairs.
module tb_sdram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] pending_count;
    logic       err_unexpected;

    always #5 clk = ~clk;

    sdram_arbiter_if u_r0_if ();
    sdram_arbiter_if u_r1_if ();
    sdram_arbiter_if u_m_if ();

    sdram_arbiter #(.MAX_PENDING(8), .PW(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r0             (u_r0_if),
        .r1             (u_r1_if),
        .master         (u_m_if),
        .pending_count  (pending_count),
        .err_unexpected (err_unexpected)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sdram_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic idle_inputs();
        u_r0_if.read = 1'b0; u_r0_if.write = 1'b0; u_r0_if.address = '0; u_r0_if.writedata = '0;
        u_r1_if.read = 1'b0; u_r1_if.write = 1'b0; u_r1_if.address = '0; u_r1_if.writedata = '0;
        u_m_if.waitrequest = 1'b0; u_m_if.readdatavalid = 1'b0; u_m_if.readdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        sdram_q.delete();
    endtask

    // Issue a read from requester id and record what the SDRAM will return for it.
    task automatic drive_read(input logic id, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        idle_inputs();
        if (id) begin u_r1_if.read = 1'b1; u_r1_if.address = addr; end
        else    begin u_r0_if.read = 1'b1; u_r0_if.address = addr; end
        #1;
        n_tests++;
        if ({u_m_if.read, u_m_if.address, (id ? u_r1_if.waitrequest : u_r0_if.waitrequest)} !== {1'b1, addr, 1'b0}) begin
            n_fail++;
            $display("FAIL issue_read r%0d: got read=%b addr=%h wait=%b want read=1 addr=%h wait=0",
                     id, u_m_if.read, u_m_if.address, (id ? u_r1_if.waitrequest : u_r0_if.waitrequest), addr);
        end
        exp_q.push_back('{id: id, data: data});
        sdram_q.push_back(data);
    endtask

    // One SDRAM response cycle; captures what both requesters see.
    task automatic sdram_respond(output logic v0, output logic v1, output logic [31:0] d0, output logic [31:0] d1);
        @(negedge clk);
        u_m_if.readdatavalid = 1'b1;
        u_m_if.readdata      = (sdram_q.size() != 0) ? sdram_q.pop_front() : 32'hDEAD_BEEF;
        #1;
        v0 = u_r0_if.readdatavalid; v1 = u_r1_if.readdatavalid;
        d0 = u_r0_if.readdata;      d1 = u_r1_if.readdata;
        @(posedge clk);
        #1;
        u_m_if.readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        u_r0_if.read = 1'b1; u_r0_if.address = 32'h44; u_r1_if.write = 1'b1;
        u_m_if.readdatavalid = 1'b1;
        #1;
        n_tests++;
        if ({u_r0_if.waitrequest, u_r1_if.waitrequest} !== 2'b11) begin
            n_fail++; $display("FAIL rst_wait: got %b%b want 11", u_r0_if.waitrequest, u_r1_if.waitrequest);
        end
        n_tests++;
        if ({u_m_if.read, u_m_if.write} !== 2'b00) begin
            n_fail++; $display("FAIL rst_cmd: got read=%b write=%b want 0 0", u_m_if.read, u_m_if.write);
        end
        n_tests++;
        if ({u_r0_if.readdatavalid, u_r1_if.readdatavalid} !== 2'b00) begin
            n_fail++; $display("FAIL rst_rdv: got %b%b want 00", u_r0_if.readdatavalid, u_r1_if.readdatavalid);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({pending_count, err_unexpected} !== 5'b0) begin
            n_fail++; $display("FAIL rst_state: got pending=%0d err=%b want 0 0", pending_count, err_unexpected);
        end
    endtask

    task automatic test_single_read();
        logic v0, v1;
        logic [31:0] d0, d1;
        exp_t e;
        drive_read(1'b0, 32'h100, 32'h0000_CAFE);
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if ({u_m_if.read, pending_count} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL single_after: got read=%b pending=%0d want 0 1", u_m_if.read, pending_count);
        end
        @(negedge clk);
        sdram_respond(v0, v1, d0, d1);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL single_sb: response with empty scoreboard");
        end else begin
            e = exp_q.pop_front();
            if ({v0, v1, d0, d1} !== {~e.id, e.id, e.data, e.data}) begin
                n_fail++; $display("FAIL single_resp: got v0=%b v1=%b d=%h want owner=%0d d=%h", v0, v1, d0, e.id, e.data);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (pending_count !== 4'd0) begin
            n_fail++; $display("FAIL single_drain: got pending=%0d want 0", pending_count);
        end
    endtask

    task automatic test_round_robin();
        logic r1_turn;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            u_r0_if.write = 1'b1; u_r0_if.address = 32'h10; u_r0_if.writedata = 32'hD0;
            u_r1_if.write = 1'b1; u_r1_if.address = 32'h20; u_r1_if.writedata = 32'hD1;
            #1;
            r1_turn = (i % 2) == 1;
            n_tests++;
            if ({u_m_if.write, u_m_if.address, u_m_if.writedata, u_r0_if.waitrequest, u_r1_if.waitrequest} !==
                {1'b1, (r1_turn ? 32'h20 : 32'h10), (r1_turn ? 32'hD1 : 32'hD0), r1_turn, ~r1_turn}) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: got wr=%b addr=%h wd=%h w0=%b w1=%b want addr=%h",
                         i, u_m_if.write, u_m_if.address, u_m_if.writedata,
                         u_r0_if.waitrequest, u_r1_if.waitrequest, (r1_turn ? 32'h20 : 32'h10));
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_lock();
        apply_reset();
        @(negedge clk);
        u_r0_if.write = 1'b1; u_r0_if.address = 32'h30; u_r0_if.writedata = 32'h3;
        #1;
        n_tests++;
        if ({u_m_if.address, u_r0_if.waitrequest} !== {32'h30, 1'b0}) begin
            n_fail++; $display("FAIL lock_pre: got addr=%h w0=%b want 30 0", u_m_if.address, u_r0_if.waitrequest);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            u_r1_if.write = 1'b1; u_r1_if.address = 32'h40; u_r1_if.writedata = 32'h4;
            u_m_if.waitrequest = 1'b1;
            #1;
            n_tests++;
            if ({u_m_if.write, u_m_if.address, u_r0_if.waitrequest, u_r1_if.waitrequest} !== {1'b1, 32'h40, 2'b11}) begin
                n_fail++; $display("FAIL lock_stall%0d: got wr=%b addr=%h w0=%b w1=%b want 1 40 1 1",
                                   i, u_m_if.write, u_m_if.address, u_r0_if.waitrequest, u_r1_if.waitrequest);
            end
        end
        @(negedge clk);
        u_m_if.waitrequest = 1'b0;
        #1;
        n_tests++;
        if ({u_m_if.address, u_r0_if.waitrequest, u_r1_if.waitrequest} !== {32'h40, 2'b10}) begin
            n_fail++; $display("FAIL lock_accept: got addr=%h w0=%b w1=%b want 40 1 0",
                               u_m_if.address, u_r0_if.waitrequest, u_r1_if.waitrequest);
        end
        @(negedge clk);
        u_r1_if.write = 1'b0;
        #1;
        n_tests++;
        if ({u_m_if.address, u_r0_if.waitrequest} !== {32'h30, 1'b0}) begin
            n_fail++; $display("FAIL lock_next: got addr=%h w0=%b want 30 0", u_m_if.address, u_r0_if.waitrequest);
        end
        // Locked requester abandons its command: grant stays one cycle, then frees.
        @(negedge clk);
        u_r0_if.write = 1'b0; u_r1_if.write = 1'b1; u_m_if.waitrequest = 1'b1;
        @(negedge clk);
        u_r1_if.write = 1'b0; u_r0_if.write = 1'b1; u_m_if.waitrequest = 1'b0;
        #1;
        n_tests++;
        if ({u_m_if.write, u_r0_if.waitrequest} !== 2'b01) begin
            n_fail++; $display("FAIL lock_drop: got wr=%b w0=%b want 0 1", u_m_if.write, u_r0_if.waitrequest);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({u_m_if.write, u_m_if.address, u_r0_if.waitrequest} !== {1'b1, 32'h30, 1'b0}) begin
            n_fail++; $display("FAIL lock_release: got wr=%b addr=%h w0=%b want 1 30 0",
                               u_m_if.write, u_m_if.address, u_r0_if.waitrequest);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_interleaved_reads();
        logic v0, v1;
        logic [31:0] d0, d1;
        exp_t e;
        apply_reset();
        drive_read(1'b0, 32'hA0, 32'hD000_0000);
        drive_read(1'b1, 32'hB0, 32'hD000_0001);
        drive_read(1'b0, 32'hC0, 32'hD000_0002);
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if (pending_count !== 4'd3) begin
            n_fail++; $display("FAIL ilv_pending: got %0d want 3", pending_count);
        end
        for (int k = 0; k < 3; k++) begin
            sdram_respond(v0, v1, d0, d1);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL ilv_sb%0d: response with empty scoreboard", k);
            end else begin
                e = exp_q.pop_front();
                if ({v0, v1, d0, d1} !== {~e.id, e.id, e.data, e.data}) begin
                    n_fail++; $display("FAIL ilv_resp%0d: got v0=%b v1=%b d=%h want owner=%0d d=%h",
                                       k, v0, v1, d0, e.id, e.data);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic v0, v1;
        logic [31:0] d0, d1;
        exp_t e;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            drive_read(1'b0, 32'h200 + 32'(4 * k), 32'h5000 + 32'(k));
        end
        @(negedge clk);
        idle_inputs();
        u_r0_if.read = 1'b1; u_r0_if.address = 32'h900;
        u_r1_if.write = 1'b1; u_r1_if.address = 32'h500; u_r1_if.writedata = 32'h55;
        #1;
        n_tests++;
        if (pending_count !== 4'd8) begin
            n_fail++; $display("FAIL full_pending: got %0d want 8", pending_count);
        end
        n_tests++;
        if ({u_r0_if.waitrequest, u_m_if.read, u_m_if.write, u_m_if.address, u_r1_if.waitrequest} !==
            {1'b1, 1'b0, 1'b1, 32'h500, 1'b0}) begin
            n_fail++; $display("FAIL full_write_pass: got w0=%b rd=%b wr=%b addr=%h w1=%b want 1 0 1 500 0",
                               u_r0_if.waitrequest, u_m_if.read, u_m_if.write, u_m_if.address, u_r1_if.waitrequest);
        end
        @(negedge clk);
        u_r1_if.write = 1'b0;
        u_m_if.readdatavalid = 1'b1;
        u_m_if.readdata = sdram_q.pop_front();
        #1;
        n_tests++;
        if ({u_r0_if.waitrequest, u_m_if.read} !== 2'b10) begin
            n_fail++; $display("FAIL full_hold: got w0=%b rd=%b want 1 0", u_r0_if.waitrequest, u_m_if.read);
        end
        v0 = u_r0_if.readdatavalid; v1 = u_r1_if.readdatavalid; d0 = u_r0_if.readdata; d1 = u_r1_if.readdata;
        n_tests++;
        e = exp_q.pop_front();
        if ({v0, v1, d0, d1} !== {~e.id, e.id, e.data, e.data}) begin
            n_fail++; $display("FAIL full_resp: got v0=%b v1=%b d=%h want owner=%0d d=%h", v0, v1, d0, e.id, e.data);
        end
        @(negedge clk);
        u_m_if.readdatavalid = 1'b0;
        #1;
        n_tests++;
        if ({pending_count, u_m_if.read, u_m_if.address, u_r0_if.waitrequest} !== {4'd7, 1'b1, 32'h900, 1'b0}) begin
            n_fail++; $display("FAIL full_ninth: got pending=%0d rd=%b addr=%h w0=%b want 7 1 900 0",
                               pending_count, u_m_if.read, u_m_if.address, u_r0_if.waitrequest);
        end
        exp_q.push_back('{id: 1'b0, data: 32'h5008});
        sdram_q.push_back(32'h5008);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            sdram_respond(v0, v1, d0, d1);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL full_sb%0d: response with empty scoreboard", k);
            end else begin
                e = exp_q.pop_front();
                if ({v0, v1, d0, d1} !== {~e.id, e.id, e.data, e.data}) begin
                    n_fail++; $display("FAIL full_drain%0d: got v0=%b v1=%b d=%h want owner=%0d d=%h",
                                       k, v0, v1, d0, e.id, e.data);
                end
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({pending_count, err_unexpected} !== 5'b0) begin
            n_fail++; $display("FAIL full_empty: got pending=%0d err=%b want 0 0", pending_count, err_unexpected);
        end
    endtask

    task automatic test_unexpected();
        logic v0, v1;
        logic [31:0] d0, d1;
        apply_reset();
        sdram_respond(v0, v1, d0, d1);
        n_tests++;
        if ({v0, v1} !== 2'b00) begin
            n_fail++; $display("FAIL unexp_rdv: got %b%b want 00", v0, v1);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({err_unexpected, pending_count} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL unexp_err: got err=%b pending=%0d want 1 0", err_unexpected, pending_count);
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (err_unexpected !== 1'b1) begin
            n_fail++; $display("FAIL unexp_sticky: got %b want 1", err_unexpected);
        end
        // Reset with a read in flight: its late response is unexpected.
        drive_read(1'b1, 32'h700, 32'h7777);
        @(negedge clk);
        idle_inputs();
        apply_reset();
        #1;
        n_tests++;
        if ({err_unexpected, pending_count} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_clear: got err=%b pending=%0d want 0 0", err_unexpected, pending_count);
        end
        sdram_respond(v0, v1, d0, d1);
        @(negedge clk);
        #1;
        n_tests++;
        if ({v0, v1, err_unexpected, pending_count} !== {2'b00, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL midrst_resp: got v0=%b v1=%b err=%b pending=%0d want 0 0 1 0",
                               v0, v1, err_unexpected, pending_count);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_interleaved_reads();
        test_fifo_full();
        test_unexpected();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
